uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the rx line, finds the start edge, samples each
// bit at its centre and presents the byte with one-cycle ok / framing-error strobes.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CNT_PER_BAUD = (CLK_FREQ + BAUD / 2) / BAUD,
    parameter int HALF_BAUD    = CNT_PER_BAUD / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ok,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [14:0] BIT_LAST  = 15'(CNT_PER_BAUD - 1);
    localparam logic [14:0] HALF_LAST = 15'(HALF_BAUD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic        rx_meta_r;
    logic        rx_s;
    logic        rx_s_d;
    logic        fall_s;

    state_t      state_r;
    state_t      state_next_s;
    logic [14:0] cnt_r;
    logic [14:0] cnt_next_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic [7:0]  data_next_s;
    logic        ok_next_s;
    logic        err_next_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_d    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
            rx_s_d    <= rx_s;
        end
    end

    assign fall_s = rx_s_d & ~rx_s;

    // Next-state, sampling and strobe decisions for the frame FSM
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r + 15'd1;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        data_next_s    = rx_data;
        ok_next_s      = 1'b0;
        err_next_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                // A start bit that is already high again at its centre was a glitch
                if (cnt_r == HALF_LAST) begin
                    if (rx_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s   = ST_DATA;
                        bit_idx_next_s = 3'd0;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    shift_next_s[bit_idx_r] = rx_s;
                    cnt_next_s              = 15'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leaving mid stop bit lets the next start edge follow with no idle gap
                if (cnt_r == BIT_LAST) begin
                    if (rx_s) begin
                        data_next_s  = shift_r;
                        ok_next_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        err_next_s   = 1'b1;
                        state_next_s = ST_BREAK;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 15'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            rx_data      <= 8'h00;
            rx_ok        <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= (state_next_s != state_r) ? 15'd0 : cnt_next_s;
            bit_idx_r    <= bit_idx_next_s;
            shift_r      <= shift_next_s;
            rx_data      <= data_next_s;
            rx_ok        <= ok_next_s;
            rx_frame_err <= err_next_s;
            rx_busy      <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a fast instance (10 clk/bit) and a
// default-rate instance driven at +/-2% line-rate offset.
module tb_uart_rx;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         fall_cyc;
        logic       chk_lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_f, rx_d;
    logic [7:0] data_f, data_d;
    logic       ok_f, ok_d, err_f, err_d, busy_f, busy_d;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       q_fast[$];
    exp_t       q_def[$];
    logic [7:0] last_good[2];

    uart_rx #(.CLK_FREQ(1000000), .BAUD(100000)) u_fast (
        .clk(clk), .rst_n(rst_n), .rx(rx_f), .rx_data(data_f),
        .rx_ok(ok_f), .rx_frame_err(err_f), .rx_busy(busy_f)
    );

    uart_rx u_def (
        .clk(clk), .rst_n(rst_n), .rx(rx_d), .rx_data(data_d),
        .rx_ok(ok_d), .rx_frame_err(err_d), .rx_busy(busy_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input logic ok, input logic err, input logic [7:0] d,
                         input logic have, input exp_t e);
        int lat;
        chk({tag, "_exclusive"}, 32'(ok & err), 32'd0);
        if (!have) begin
            chk({tag, "_unexpected_pulse"}, 32'({ok, err}), 32'd0);
        end else begin
            chk({tag, "_kind"}, 32'(err), 32'(e.is_err));
            chk({tag, "_data"}, 32'(d), 32'(e.data));
            if (e.chk_lat) begin
                lat = cyc - e.fall_cyc;
                chk({tag, "_latency_in_96_98"}, 32'(lat >= 96 && lat <= 98), 32'd1);
            end
        end
    endtask

    // Monitors: every strobe pops the oldest expected frame outcome
    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (rst_n === 1'b1 && (ok_f || err_f)) begin
            have = (q_fast.size() > 0);
            if (have) e = q_fast.pop_front();
            score("fast", ok_f, err_f, data_f, have, e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (rst_n === 1'b1 && (ok_d || err_d)) begin
            have = (q_def.size() > 0);
            if (have) e = q_def.pop_front();
            score("def", ok_d, err_d, data_d, have, e);
        end
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_f = v;
        else rx_d = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: a good stop bit delivers the byte; a low stop bit flags an
    // error and leaves the last good byte visible. Line is left low on a bad stop.
    task automatic send(input int which, input logic [7:0] b, input logic stop,
                        input int bitlen, input logic chk_lat);
        exp_t e;
        e.is_err   = ~stop;
        e.data     = stop ? b : last_good[which];
        e.fall_cyc = cyc;
        e.chk_lat  = chk_lat;
        if (stop) last_good[which] = b;
        if (which == 0) q_fast.push_back(e);
        else q_def.push_back(e);
        set_line(which, 1'b0);
        idle(bitlen);
        chk("busy_in_frame", 32'((which == 0) ? busy_f : busy_d), 32'd1);
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            idle(bitlen);
        end
        set_line(which, stop);
        idle(bitlen);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] rb;
        logic rs;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        rst_n = 1'b0;
        rx_f  = 1'b1;
        rx_d  = 1'b1;
        idle(3);
        chk("reset_data", 32'(data_f), 32'h00);
        chk("reset_ok", 32'(ok_f), 32'd0);
        chk("reset_err", 32'(err_f), 32'd0);
        chk("reset_busy", 32'(busy_f), 32'd0);
        chk("reset_def_data", 32'(data_d), 32'h00);
        rst_n = 1'b1;
        idle(5);
        chk("idle_busy", 32'(busy_f), 32'd0);

        // Single frame with latency check, then back-to-back frames
        send(0, 8'hA5, 1'b1, 10, 1'b1);
        idle(10);
        send(0, 8'h00, 1'b1, 10, 1'b1);
        send(0, 8'hFF, 1'b1, 10, 1'b1);
        send(0, 8'h3C, 1'b1, 10, 1'b1);
        idle(20);

        // Short low glitch must not start a frame
        rx_f = 1'b0;
        idle(3);
        chk("glitch_busy_seen", 32'(busy_f), 32'd1);
        rx_f = 1'b1;
        for (int i = 0; i < 9 && busy_f; i++) @(negedge clk);
        chk("glitch_busy_clear", 32'(busy_f), 32'd0);
        idle(10);

        // Bad stop bit followed by a held-low break
        send(0, 8'h55, 1'b0, 10, 1'b1);
        idle(50);
        chk("break_busy_held", 32'(busy_f), 32'd1);
        chk("break_data_kept", 32'(data_f), 32'(last_good[0]));
        rx_f = 1'b1;
        cnt = 0;
        while (busy_f && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("break_release_2_4", 32'(cnt >= 2 && cnt <= 4), 32'd1);
        idle(10);
        send(0, 8'h81, 1'b1, 10, 1'b1);
        idle(20);

        // Reset in the middle of data bit 4 of 0xC3
        rb = 8'hC3;
        rx_f = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            rx_f = rb[i];
            idle(10);
        end
        rx_f = rb[4];
        idle(5);
        rst_n = 1'b0;
        rx_f  = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        idle(2);
        chk("midreset_busy", 32'(busy_f), 32'd0);
        rst_n = 1'b1;
        idle(20);
        chk("after_reset_data", 32'(data_f), 32'h00);
        chk("after_reset_busy", 32'(busy_f), 32'd0);
        send(0, 8'h7E, 1'b1, 10, 1'b1);
        idle(10);

        // Randomised frames, occasionally with a low stop bit and break
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            send(0, rb, rs, 10, 1'b1);
            if (!rs) begin
                idle($urandom_range(0, 20));
                rx_f = 1'b1;
                idle(4 + $urandom_range(0, 5));
            end else begin
                idle($urandom_range(0, 5));
            end
        end
        idle(20);

        // Default rate with +2% and -2% bit-length offsets
        send(1, 8'h96, 1'b1, 425, 1'b0);
        idle(50);
        send(1, 8'h69, 1'b1, 443, 1'b0);
        idle(50);
        chk("def_final_data", 32'(data_d), 32'h69);

        chk("fast_queue_drained", 32'(q_fast.size()), 32'd0);
        chk("def_queue_drained", 32'(q_def.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
